// File: rtl/ddr_cmd_issuer.sv
// DDR command/address bus generator: per-bank open-row tracking, PR/ACT/RD/WR
// sequencing with TRP/TRCD spacing, and periodic all-bank precharge plus refresh.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting; accepts a request or starts a pending refresh
// ST_PRE      | PR for a row miss is on the bus
// ST_PRE_WAIT | waiting out TRP before the ACT
// ST_ACT      | ACT is on the bus
// ST_ACT_WAIT | waiting out TRCD before the RD/WR
// ST_RW       | RD/WR is on the bus
// ST_RPRA     | PRA ahead of a refresh is on the bus
// ST_RPRA_WAIT| waiting out TRP before the REF
// ST_RREF     | REF is on the bus
// ST_RREF_WAIT| waiting out TRFC before returning to idle
module ddr_cmd_issuer #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 1,
  parameter int BGWIDTH       = $clog2(BANKGROUPS),
  parameter int BANKSPERGROUP = 8,
  parameter int BAWIDTH       = $clog2(BANKSPERGROUP),
  parameter int ROWS          = 512,
  parameter int COLUMNS       = 512,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TRFC          = 16,
  parameter int TREFI         = 780
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [BGWIDTH:0]           req_bg,
  input  logic [BAWIDTH:0]           req_ba,
  input  logic [$clog2(ROWS)-1:0]    req_row,
  input  logic [$clog2(COLUMNS)-1:0] req_col,
  output logic                       reset_n,
  output logic                       cke,
  output logic                       cs_n,
  output logic                       act_n,
  output logic [ADDRWIDTH-1:0]       adr,
  output logic [BAWIDTH:0]           ba,
  output logic [BGWIDTH:0]           bg,
  output logic                       cmd_issued
);

  localparam int ROWW = $clog2(ROWS);
  localparam int COLW = $clog2(COLUMNS);
  localparam int IDXW = BGWIDTH + BAWIDTH + 2;
  localparam int NIDX = 2 ** IDXW;
  localparam int CNTW = 16;
  localparam int REFW = $clog2(TREFI + 1);

  localparam logic [3:0] CMD_ACT = 4'd1;
  localparam logic [3:0] CMD_PR  = 4'd3;
  localparam logic [3:0] CMD_RD  = 4'd4;
  localparam logic [3:0] CMD_REF = 4'd5;
  localparam logic [3:0] CMD_WR  = 4'd6;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PRE, ST_PRE_WAIT, ST_ACT, ST_ACT_WAIT, ST_RW,
    ST_RPRA, ST_RPRA_WAIT, ST_RREF, ST_RREF_WAIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNTW-1:0]     r_cnt, w_cnt_nxt;
  logic [REFW-1:0]     r_ref_cnt;
  logic                r_ref_pending;
  logic                r_init_done;

  logic                r_reset_n, r_cke, r_cs_n, r_act_n, r_cmd_issued;
  logic [ADDRWIDTH-1:0] r_adr;
  logic [BAWIDTH:0]    r_ba;
  logic [BGWIDTH:0]    r_bg;

  logic                r_we;
  logic [BGWIDTH:0]    r_req_bg;
  logic [BAWIDTH:0]    r_req_ba;
  logic [ROWW-1:0]     r_row;
  logic [COLW-1:0]     r_col;

  logic [NIDX-1:0]     r_open;
  logic [ROWW-1:0]     r_open_row [NIDX];

  logic                w_src_we;
  logic [BGWIDTH:0]    w_src_bg;
  logic [BAWIDTH:0]    w_src_ba;
  logic [ROWW-1:0]     w_src_row;
  logic [COLW-1:0]     w_src_col;
  logic [IDXW-1:0]     w_src_idx;
  logic                w_ready, w_accept, w_hit;
  logic [ADDRWIDTH-1:0] w_act_adr, w_rw_adr, w_pr_adr, w_pra_adr, w_ref_adr;

  logic                w_issue, w_is_act, w_bank_cmd;
  logic [ADDRWIDTH-1:0] w_cmd_adr;
  logic                w_set_open, w_clr_open, w_clr_all, w_ref_issue;

  function automatic logic [ADDRWIDTH-1:0] f_code(input logic [3:0] code);
    logic [ADDRWIDTH-1:0] a;
    a = '0;
    a[ADDRWIDTH-1 -: 4] = code;
    return a;
  endfunction

  // In IDLE the command is built straight from the request so it lands on the bus one cycle after acceptance.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_src_we  = req_we;
      w_src_bg  = req_bg;
      w_src_ba  = req_ba;
      w_src_row = req_row;
      w_src_col = req_col;
    end else begin
      w_src_we  = r_we;
      w_src_bg  = r_req_bg;
      w_src_ba  = r_req_ba;
      w_src_row = r_row;
      w_src_col = r_col;
    end
  end

  assign w_src_idx = {w_src_bg, w_src_ba};
  assign w_ready   = (r_state == ST_IDLE) && !r_ref_pending && r_init_done;
  assign w_accept  = w_ready && req_valid;
  assign w_hit     = r_open[w_src_idx] && (r_open_row[w_src_idx] == w_src_row);

  assign w_act_adr = f_code(CMD_ACT) | ADDRWIDTH'(w_src_row);
  assign w_rw_adr  = f_code(w_src_we ? CMD_WR : CMD_RD) | ADDRWIDTH'(w_src_col);
  assign w_pr_adr  = f_code(CMD_PR);
  assign w_pra_adr = f_code(CMD_PR) | (ADDRWIDTH'(1) << 10);
  assign w_ref_adr = f_code(CMD_REF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_is_act    = 1'b0;
    w_bank_cmd  = 1'b0;
    w_cmd_adr   = '0;
    w_set_open  = 1'b0;
    w_clr_open  = 1'b0;
    w_clr_all   = 1'b0;
    w_ref_issue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ref_pending) begin
          w_issue = 1'b1;
          if (|r_open) begin
            w_cmd_adr   = w_pra_adr;
            w_clr_all   = 1'b1;
            w_state_nxt = ST_RPRA;
            w_cnt_nxt   = CNTW'(TRP - 1);
          end else begin
            w_cmd_adr   = w_ref_adr;
            w_ref_issue = 1'b1;
            w_state_nxt = ST_RREF;
            w_cnt_nxt   = CNTW'(TRFC - 1);
          end
        end else if (w_accept) begin
          w_issue    = 1'b1;
          w_bank_cmd = 1'b1;
          if (w_hit) begin
            w_cmd_adr   = w_rw_adr;
            w_state_nxt = ST_RW;
          end else if (r_open[w_src_idx]) begin
            w_cmd_adr   = w_pr_adr;
            w_clr_open  = 1'b1;
            w_state_nxt = ST_PRE;
            w_cnt_nxt   = CNTW'(TRP - 1);
          end else begin
            w_cmd_adr   = w_act_adr;
            w_is_act    = 1'b1;
            w_set_open  = 1'b1;
            w_state_nxt = ST_ACT;
            w_cnt_nxt   = CNTW'(TRCD - 1);
          end
        end
      end
      ST_PRE, ST_PRE_WAIT: begin
        if (r_cnt == '0) begin
          w_issue     = 1'b1;
          w_bank_cmd  = 1'b1;
          w_is_act    = 1'b1;
          w_cmd_adr   = w_act_adr;
          w_set_open  = 1'b1;
          w_state_nxt = ST_ACT;
          w_cnt_nxt   = CNTW'(TRCD - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CNTW'(1);
          w_state_nxt = ST_PRE_WAIT;
        end
      end
      ST_ACT, ST_ACT_WAIT: begin
        if (r_cnt == '0) begin
          w_issue     = 1'b1;
          w_bank_cmd  = 1'b1;
          w_cmd_adr   = w_rw_adr;
          w_state_nxt = ST_RW;
        end else begin
          w_cnt_nxt   = r_cnt - CNTW'(1);
          w_state_nxt = ST_ACT_WAIT;
        end
      end
      ST_RW: w_state_nxt = ST_IDLE;
      ST_RPRA, ST_RPRA_WAIT: begin
        if (r_cnt == '0) begin
          w_issue     = 1'b1;
          w_cmd_adr   = w_ref_adr;
          w_ref_issue = 1'b1;
          w_state_nxt = ST_RREF;
          w_cnt_nxt   = CNTW'(TRFC - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CNTW'(1);
          w_state_nxt = ST_RPRA_WAIT;
        end
      end
      ST_RREF, ST_RREF_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - CNTW'(1);
          w_state_nxt = ST_RREF_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reset_n     <= 1'b0;
      r_cke         <= 1'b0;
      r_init_done   <= 1'b0;
      r_cs_n        <= 1'b1;
      r_act_n       <= 1'b1;
      r_adr         <= '0;
      r_ba          <= '0;
      r_bg          <= '0;
      r_cmd_issued  <= 1'b0;
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
      r_we          <= 1'b0;
      r_req_bg      <= '0;
      r_req_ba      <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_open        <= '0;
    end else begin
      r_reset_n    <= 1'b1;
      r_cke        <= 1'b1;
      r_init_done  <= r_reset_n;
      r_cs_n       <= !w_issue;
      r_act_n      <= !w_is_act;
      r_adr        <= w_cmd_adr;
      r_cmd_issued <= w_issue;
      if (w_bank_cmd) begin
        r_ba <= w_src_ba;
        r_bg <= w_src_bg;
      end

      // A wrap while a refresh is already pending is dropped, not queued.
      if (r_ref_cnt == REFW'(TREFI - 1)) begin
        r_ref_cnt <= '0;
        if (!r_ref_pending) r_ref_pending <= 1'b1;
        else if (w_ref_issue) r_ref_pending <= 1'b0;
      end else begin
        r_ref_cnt <= r_ref_cnt + REFW'(1);
        if (w_ref_issue) r_ref_pending <= 1'b0;
      end

      if (w_accept) begin
        r_we     <= req_we;
        r_req_bg <= req_bg;
        r_req_ba <= req_ba;
        r_row    <= req_row;
        r_col    <= req_col;
      end

      if (w_clr_all) r_open <= '0;
      else if (w_clr_open) r_open[w_src_idx] <= 1'b0;
      else if (w_set_open) r_open[w_src_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_set_open) r_open_row[w_src_idx] <= w_src_row;
  end

  assign req_ready  = w_ready;
  assign reset_n    = r_reset_n;
  assign cke        = r_cke;
  assign cs_n       = r_cs_n;
  assign act_n      = r_act_n;
  assign adr        = r_adr;
  assign ba         = r_ba;
  assign bg         = r_bg;
  assign cmd_issued = r_cmd_issued;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Bench for ddr_cmd_issuer: a cycle-scheduled command model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ddr_cmd_issuer;
  localparam int TRCD = 3, TRP = 3, TRFC = 8, TREFI = 200;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [0:0]  req_bg = '0;
  logic [3:0]  req_ba = '0;
  logic [8:0]  req_row = '0, req_col = '0;
  logic        reset_n, cke, cs_n, act_n, cmd_issued;
  logic [16:0] adr;
  logic [3:0]  ba;
  logic [0:0]  bg;

  ddr_cmd_issuer #(.TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TREFI(TREFI)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n), .adr(adr), .ba(ba), .bg(bg),
    .cmd_issued(cmd_issued));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) if (rst) cyc <= 0; else cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model: every command is placed on a timeline of bus cycles when its request is decided.
  bit mopen [32];
  int mrow  [32];
  bit pending;
  int next_ref, idle_from, ref_clear_at, last_ba, last_bg;
  int e_adr [int];
  int e_ba  [int];
  int e_bg  [int];
  bit e_act [int];

  localparam int A_ACT = 1 << 13, A_PR = 3 << 13, A_RD = 4 << 13, A_REF = 5 << 13, A_WR = 6 << 13;

  function automatic void sched(input int cy, input int a, input int b_ba, input int b_bg, input bit is_act);
    e_adr[cy] = a; e_ba[cy] = b_ba; e_bg[cy] = b_bg; e_act[cy] = is_act;
  endfunction

  always @(negedge clk) begin
    int c, idx, xa, xcs, xact, xci, xrdy, rwa;
    bit anyo;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mopen[i] = 0; mrow[i] = 0; end
      pending = 0; next_ref = TREFI; idle_from = 0; ref_clear_at = -1; last_ba = 0; last_bg = 0;
      e_adr.delete(); e_ba.delete(); e_bg.delete(); e_act.delete();
      chk("rst_reset_n", reset_n, 0); chk("rst_cke", cke, 0); chk("rst_cs_n", cs_n, 1);
      chk("rst_act_n", act_n, 1); chk("rst_adr", adr, 0); chk("rst_ba", ba, 0); chk("rst_bg", bg, 0);
      chk("rst_cmd_issued", cmd_issued, 0); chk("rst_req_ready", req_ready, 0);
    end else begin
      c = cyc;
      if (c == ref_clear_at) pending = 0;
      if (c == next_ref) begin pending = 1; next_ref += TREFI; end
      xcs = 1; xact = 1; xa = 0; xci = 0;
      if (e_adr.exists(c)) begin
        xcs = 0; xci = 1; xa = e_adr[c]; xact = e_act[c] ? 0 : 1;
        if (e_ba[c] >= 0) begin last_ba = e_ba[c]; last_bg = e_bg[c]; end
        e_adr.delete(c); e_ba.delete(c); e_bg.delete(c); e_act.delete(c);
      end
      xrdy = (c >= 2 && c >= idle_from && !pending) ? 1 : 0;
      chk("reset_n", reset_n, (c >= 1) ? 1 : 0);
      chk("cke", cke, (c >= 1) ? 1 : 0);
      chk("cs_n", cs_n, xcs);
      chk("act_n", act_n, xact);
      chk("adr", adr, xa);
      chk("cmd_issued", cmd_issued, xci);
      chk("ba", ba, last_ba);
      chk("bg", bg, last_bg);
      chk("req_ready", req_ready, xrdy);

      if (c >= idle_from && pending) begin
        anyo = 0;
        for (int i = 0; i < 32; i++) if (mopen[i]) anyo = 1;
        if (anyo) begin
          sched(c + 1, A_PR | (1 << 10), -1, -1, 0);
          sched(c + 1 + TRP, A_REF, -1, -1, 0);
          ref_clear_at = c + 1 + TRP;
          idle_from = c + 1 + TRP + TRFC;
          for (int i = 0; i < 32; i++) mopen[i] = 0;
        end else begin
          sched(c + 1, A_REF, -1, -1, 0);
          ref_clear_at = c + 1;
          idle_from = c + 1 + TRFC;
        end
      end else if (xrdy == 1 && req_valid) begin
        idx = int'(req_bg) * 16 + int'(req_ba);
        rwa = (req_we ? A_WR : A_RD) | int'(req_col);
        if (mopen[idx] && mrow[idx] == int'(req_row)) begin
          sched(c + 1, rwa, req_ba, req_bg, 0);
          idle_from = c + 2;
        end else if (!mopen[idx]) begin
          sched(c + 1, A_ACT | int'(req_row), req_ba, req_bg, 1);
          sched(c + 1 + TRCD, rwa, req_ba, req_bg, 0);
          idle_from = c + 2 + TRCD;
        end else begin
          sched(c + 1, A_PR, req_ba, req_bg, 0);
          sched(c + 1 + TRP, A_ACT | int'(req_row), req_ba, req_bg, 1);
          sched(c + 1 + TRP + TRCD, rwa, req_ba, req_bg, 0);
          idle_from = c + 2 + TRP + TRCD;
        end
        mopen[idx] = 1;
        mrow[idx] = int'(req_row);
      end
    end
  end

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cyc == target) return;
      if (cyc > target) break;
    end
    n_tests++; n_fail++;
    $display("FAIL wait_cyc: at cycle %0d, required cycle %0d", cyc, target);
  endtask

  task automatic send(input bit we, input int b, input int row, input int col, output int t);
    req_valid = 1'b1; req_we = we; req_bg = '0; req_ba = 4'(b); req_row = 9'(row); req_col = 9'(col);
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) begin
      n_tests++; n_fail++;
      $display("FAIL send: request never accepted, ready=%0b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    int t, pulses;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    wait_cyc(1);
    chk("init_reset_n_c1", reset_n, 1); chk("init_cke_c1", cke, 1); chk("init_ready_c1", req_ready, 0);
    wait_cyc(2);
    chk("init_ready_c2", req_ready, 1); chk("init_cs_n_c2", cs_n, 1);

    @(posedge clk); #1;
    send(0, 2, 5, 'h10, t);
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      wait_cyc(t + k);
      pulses += int'(cmd_issued);
      if (k == 1) begin chk("rd1_act_n", act_n, 0); chk("rd1_act_adr", adr, 'h02005); chk("rd1_act_ba", ba, 2); end
      if (k == 4) begin chk("rd1_rd_adr", adr, 'h08010); chk("rd1_rd_act_n", act_n, 1); end
    end
    chk("rd1_pulses", pulses, 2);

    @(posedge clk); #1;
    send(1, 2, 5, 'h21, t);
    wait_cyc(t + 1);
    chk("wr_hit_adr", adr, 'h0C021); chk("wr_hit_act_n", act_n, 1);

    @(posedge clk); #1;
    send(0, 2, 7, 'h33, t);
    wait_cyc(t + 1);
    chk("miss_pr_adr10", adr[10], 0); chk("miss_pr_adr", adr, 'h06000); chk("miss_pr_ba", ba, 2);
    wait_cyc(t + 4);
    chk("miss_act_adr", adr, 'h02007); chk("miss_act_n", act_n, 0);
    wait_cyc(t + 7);
    chk("miss_rd_adr", adr, 'h08033);

    while (cyc < 200) begin @(posedge clk); #1; end
    fork
      send(0, 2, 7, 'h44, t);
      begin
        wait_cyc(200); chk("ref_ready_c200", req_ready, 0);
        wait_cyc(201); chk("ref_pra_adr", adr, 'h06400);
        wait_cyc(204); chk("ref_ref_adr", adr, 'h0A000);
      end
    join
    chk("ref_accept_cycle", t, 212);
    wait_cyc(213);
    chk("ref_react_act_n", act_n, 0); chk("ref_react_adr", adr, 'h02007);
    wait_cyc(217);

    @(posedge clk); #1;
    send(0, 3, 9, 1, t);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_reset_n", reset_n, 0); chk("abort_cke", cke, 0); chk("abort_cs_n", cs_n, 1);
    chk("abort_act_n", act_n, 1); chk("abort_adr", adr, 0); chk("abort_cmd_issued", cmd_issued, 0);
    chk("abort_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(0, 3, 9, 1, t);
    chk("abort_accept_cycle", t, 2);
    wait_cyc(t + 1);
    chk("abort_react_act_n", act_n, 0); chk("abort_react_adr", adr, 'h02009); chk("abort_react_ba", ba, 3);

    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_bg    = '0;
      req_ba    = 4'($urandom_range(0, 7));
      req_row   = 9'($urandom_range(0, 2));
      req_col   = 9'($urandom_range(0, 511));
    end
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_issuer.md
Name: ddr_cmd_issuer

Overview:
- Controller-side command generator that drives the DIMM command/address bus: cke, cs_n, act_n, adr, ba, bg, reset_n.
- Accepts read/write requests over a valid/ready handshake and tracks the open row of every bank.
- Issues PR/ACT/RD/WR with TRP/TRCD spacing, plus periodic all-bank precharge and refresh.
- Command code is carried in adr[ADDRWIDTH-1:ADDRWIDTH-4]: 1=ACT, 3=PR/PRA, 4=RD, 5=REF, 6=WR.

Parameters:
- ADDRWIDTH, 17, command/address bus width.
- BANKGROUPS, 1, bank groups.
- BGWIDTH, $clog2(BANKGROUPS), bank-group index width.
- BANKSPERGROUP, 8, banks per group.
- BAWIDTH, $clog2(BANKSPERGROUP), bank index width.
- ROWS, 512, rows per bank.
- COLUMNS, 512, columns per row.
- TRCD, 4, cycles from ACT to RD/WR (>=1).
- TRP, 4, cycles from PR/PRA to next ACT/REF (>=1).
- TRFC, 16, cycles from REF to next command (>=1).
- TREFI, 780, cycles between refresh requests.

Ports:
- clk  in  1  command clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1=write, 0=read.
- req_bg  in  BGWIDTH+1  bank group.
- req_ba  in  BAWIDTH+1  bank.
- req_row  in  $clog2(ROWS)  row.
- req_col  in  $clog2(COLUMNS)  column.
- reset_n  out  1  DRAM reset.
- cke  out  1  clock enable.
- cs_n  out  1  chip select; low only in command cycles.
- act_n  out  1  low only during ACT.
- adr  out  ADDRWIDTH  command code plus row/column.
- ba  out  BAWIDTH+1  bank.
- bg  out  BGWIDTH+1  bank group.
- cmd_issued  out  1  one-cycle pulse coincident with every cs_n=0 cycle.

Behaviour:
- Reset values (async, while rst=1):
  - reset_n=0, cke=0, cs_n=1, act_n=1, adr=0, ba=0, bg=0, cmd_issued=0, req_ready=0.
  - All open flags cleared; refresh counter=0; ref_pending=0; FSM=IDLE.
- After reset release:
  - reset_n=1 and cke=1 from the first clock edge.
  - req_ready may assert from the second edge.
- All bus outputs are registered.
- NOP cycle: cs_n=1, act_n=1, adr=0, ba/bg hold their last value.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, RPRA, RPRA_WAIT, RREF, RREF_WAIT.
- IDLE:
  - req_ready=1 only in IDLE with ref_pending=0 and init done.
  - The request is latched on acceptance.
  - Row hit (bank open, same row) -> RW.
  - Bank closed -> ACT.
  - Bank open, different row -> PRE.
- Timing, with acceptance in cycle t:
  - Hit: RD/WR on the bus at t+1.
  - Closed: ACT at t+1, RD/WR at t+1+TRCD.
  - Miss: PR at t+1, ACT at t+1+TRP, RD/WR at t+1+TRP+TRCD.
- Commands:
  - PR: adr[10]=0; clears that bank's open flag.
  - ACT: act_n=0, adr low bits=row; sets open flag and open row.
  - RD/WR: adr low bits=column.
  - ba/bg carry the target bank in every command.
- RW issues a single command, then returns to IDLE. Back-to-back hits are therefore 2 cycles apart.
- Wait states:
  - A down-counter loaded with TRP-1 / TRCD-1 / TRFC-1.
  - The following command issues in the cycle after the count reaches 0.
- Refresh:
  - Free-running counter from reset. At TREFI-1 it wraps to 0 and sets ref_pending.
  - A wrap while already pending does nothing (no queuing).
  - In IDLE with ref_pending=1, refresh wins over a simultaneous req_valid.
  - If any bank is open: PRA (code 3, adr[10]=1, all open flags cleared), wait TRP, then REF.
  - If no bank is open: REF directly.
  - ref_pending clears when REF issues. After TRFC, return to IDLE.
- A pending refresh never interrupts an in-flight request; it waits until the FSM is in IDLE.
- req_* inputs are ignored outside acceptance.
- Reset mid-operation aborts immediately to reset values. No partial command is completed.

Test Plan:
- Use TRCD=3, TRP=3, TRFC=8, TREFI=200 for all scenarios.
- Reset release -> reset_n=1 and cke=1 after 1 edge, req_ready=1 after 2 edges, cs_n=1 throughout.
- Read bank 2, row 0x05, col 0x10 accepted at t:
  - ACT (act_n=0, adr=0x02005, ba=2) at t+1.
  - RD (adr=0x08010) at t+4.
  - cmd_issued pulses exactly twice.
- Write to the same bank/row after the first read -> WR (adr=0x0C000|col) 1 cycle after acceptance, no ACT.
- Read bank 2, row 0x07 while row 0x05 is open -> PR (adr[10]=0, ba=2) at t+1, ACT row 7 at t+4, RD at t+7.
- Counter reaches TREFI with bank 2 open and req_valid=1 in the same IDLE cycle:
  - req_ready=0.
  - PRA (adr=0x06400), then REF (adr=0x0A000) 3 cycles later.
  - Request accepted 8 cycles after REF.
  - Request then re-ACTs its row, since the PRA closed it.
- Assert rst during ACT_WAIT -> all outputs at reset values in the same cycle, open flags cleared. The next read to that bank issues ACT first.
